// File: rtl/i2c_master_ctrl_pkg.sv
// ============================================================================
// Module : i2c_pkg
// Brief  : 8-bit I2C master state codes shared by the controller and datapath.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package i2c_pkg;

    typedef enum logic [7:0] {
        IDLE       = 8'd0,
        START      = 8'd1,
        ADDRESS    = 8'd2,
        READ_ACK   = 8'd3,
        WRITE_DATA = 8'd4,
        READ_DATA  = 8'd5,
        READ_ACK2  = 8'd6,
        WRITE_ACK2 = 8'd7,
        STOP       = 8'd8
    } i2c_state_e;

    localparam logic [3:0] COUNT_MSB = 4'd7;

endpackage

`default_nettype wire

// File: rtl/i2c_master_ctrl_if.sv
// ============================================================================
// Module : i2c_master_ctrl_if
// Brief  : Host/bus/datapath-facing signal bundle of the I2C master sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

interface i2c_master_ctrl_if;
    logic       start_req;
    logic       rw;
    logic       sda_in;
    logic       scl;
    logic       dp_clk;
    logic [7:0] state;
    logic [3:0] count;
    logic       i2c_scl_en;
    logic       i2c_write_en;
    logic       busy;
    logic       done;
    logic       ack_err;

    modport master (
        input  start_req, rw, sda_in,
        output scl, dp_clk, state, count, i2c_scl_en, i2c_write_en,
               busy, done, ack_err
    );

    modport slave (
        output start_req, rw, sda_in,
        input  scl, dp_clk, state, count, i2c_scl_en, i2c_write_en,
               busy, done, ack_err
    );
endinterface

`default_nettype wire

// File: rtl/i2c_master_ctrl_clk_gen.sv
// ============================================================================
// Module : i2c_clk_gen
// Brief  : Quarter-bit divider and phase counter; idles at P0 when not running.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_clk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       run,
    output logic [1:0] phase,
    output logic       phase_tick,
    output logic       bit_tick
);

    localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] divider;

    assign phase_tick = run && (divider == DIV_LAST);
    assign bit_tick   = phase_tick && (phase == 2'd3);

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            divider <= '0;
            phase   <= 2'd0;
        end else if (!run) begin
            divider <= '0;
            phase   <= 2'd0;
        end else if (phase_tick) begin
            divider <= '0;
            phase   <= phase + 2'd1;
        end else begin
            divider <= divider + DIV_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/i2c_master_ctrl.sv
// ============================================================================
// Module : i2c_master_ctrl
// Brief  : I2C master sequencer: FSM, SCL/dp_clk generation and ACK checking.
// Rev    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_master_ctrl
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic               clk,
    input  logic               resetN,
    i2c_master_ctrl_if.master  bus
);

    i2c_state_e state, state_nx;
    logic [3:0] count, count_nx;
    logic       rw_lat, rw_nx;
    logic       ack_err, ack_err_nx;
    logic       done_r, done_nx;
    logic       nack;
    logic [1:0] phase;
    logic       phase_tick, bit_tick;
    logic       scl_d, dp_clk_d;

    i2c_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .clk        (clk),
        .resetN     (resetN),
        .run        (state != IDLE),
        .phase      (phase),
        .phase_tick (phase_tick),
        .bit_tick   (bit_tick)
    );

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state   <= IDLE;
            count   <= COUNT_MSB;
            rw_lat  <= 1'b0;
            ack_err <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state   <= state_nx;
            count   <= count_nx;
            rw_lat  <= rw_nx;
            ack_err <= ack_err_nx;
            done_r  <= done_nx;
        end
    end

    // ACK slot is sampled mid-bit, on the P1->P2 edge while SCL rises
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            nack <= 1'b0;
        end else if (phase_tick && phase == 2'd1 &&
                     (state == READ_ACK || state == READ_ACK2)) begin
            nack <= bus.sda_in;
        end
    end

    always_comb begin
        state_nx   = state;
        count_nx   = count;
        rw_nx      = rw_lat;
        ack_err_nx = ack_err;
        done_nx    = 1'b0;
        if (state == IDLE) begin
            if (bus.start_req) begin
                state_nx   = START;
                count_nx   = COUNT_MSB;
                rw_nx      = bus.rw;
                ack_err_nx = 1'b0;
            end
        end else if (bit_tick) begin
            count_nx = COUNT_MSB;
            case (state)
                START:      state_nx = ADDRESS;
                ADDRESS: begin
                    if (count == 4'd0) state_nx = READ_ACK;
                    else               count_nx = count - 4'd1;
                end
                READ_ACK: begin
                    if (nack) begin
                        state_nx   = STOP;
                        ack_err_nx = 1'b1;
                    end else begin
                        state_nx = rw_lat ? READ_DATA : WRITE_DATA;
                    end
                end
                WRITE_DATA: begin
                    if (count == 4'd0) state_nx = READ_ACK2;
                    else               count_nx = count - 4'd1;
                end
                READ_DATA: begin
                    if (count == 4'd0) state_nx = WRITE_ACK2;
                    else               count_nx = count - 4'd1;
                end
                READ_ACK2: begin
                    state_nx = STOP;
                    if (nack) ack_err_nx = 1'b1;
                end
                WRITE_ACK2: state_nx = STOP;
                STOP: begin
                    state_nx = IDLE;
                    done_nx  = 1'b1;
                end
                default:    state_nx = IDLE;
            endcase
        end
    end

    // START/STOP move the dp_clk low pulse to P2 so it straddles the SDA edge
    always_comb begin
        scl_d    = 1'b1;
        dp_clk_d = 1'b1;
        case (state)
            IDLE: begin
                scl_d    = 1'b1;
                dp_clk_d = 1'b1;
            end
            START: begin
                scl_d    = 1'b1;
                dp_clk_d = (phase != 2'd2);
            end
            STOP: begin
                scl_d    = (phase != 2'd0);
                dp_clk_d = (phase != 2'd2);
            end
            default: begin
                scl_d    = phase[1];
                dp_clk_d = (phase != 2'd1);
            end
        endcase
    end

    assign bus.scl          = scl_d;
    assign bus.dp_clk       = dp_clk_d;
    assign bus.state        = state;
    assign bus.count        = count;
    assign bus.i2c_scl_en   = state inside {ADDRESS, READ_ACK, WRITE_DATA,
                                            READ_DATA, READ_ACK2, WRITE_ACK2};
    assign bus.i2c_write_en = state inside {START, ADDRESS, WRITE_DATA,
                                            WRITE_ACK2, STOP};
    assign bus.busy         = (state != IDLE);
    assign bus.done         = done_r;
    assign bus.ack_err      = ack_err;

endmodule

`default_nettype wire
